// File: rtl/bist_pkg.sv
// Shared BIST definitions: ORA state encoding, default MISR taps, parameter checks.
package bist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCompact,
    StCompare,
    StDone
  } ora_state_e;

  // Taps 7,5,4,3: maximal-length feedback for an 8-bit register.
  localparam logic [7:0] DefaultPoly8 = 8'hB8;

  // Counter must be able to index every pattern of a run.
  function automatic bit cnt_w_fits(int unsigned cnt_w, int unsigned num_patterns);
    return (cnt_w < 32) ? (num_patterns <= (32'd1 << cnt_w)) : 1'b1;
  endfunction

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register: shift with XOR feedback, fold in one word per step.
module misr_reg #(
  parameter int unsigned     WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] misr_q;
  logic [WIDTH-1:0] misr_step;
  logic             fb;

  // Next signature if this cycle's word is compacted.
  always_comb begin
    fb        = ^(misr_q & POLY);
    misr_step = {misr_q[WIDTH-2:0], fb} ^ din;
  end

  // Reset and load both return to the seed; load wins over a shift.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      misr_q <= SEED;
    end else if (shift_en) begin
      misr_q <= misr_step;
    end
  end

  assign q = misr_q;

endmodule

// File: rtl/misr_signature_checker.sv
// BIST output response analyser: compacts NUM_PATTERNS responses, compares with golden.
module misr_signature_checker
  import bist_pkg::*;
#(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] POLY         = WIDTH'(DefaultPoly8),
  parameter logic [WIDTH-1:0] SEED         = '0,
  parameter int unsigned      NUM_PATTERNS = 255,
  parameter int unsigned      CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_in,
  input  logic [WIDTH-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);

  if (!cnt_w_fits(CNT_W, NUM_PATTERNS) || NUM_PATTERNS < 1 || WIDTH < 2) begin : gen_bad_params
    $error("misr_signature_checker: illegal WIDTH/CNT_W/NUM_PATTERNS combination");
  end

  localparam logic [CNT_W-1:0] LastCount = CNT_W'(NUM_PATTERNS - 1);

  ora_state_e       state_q;
  logic [CNT_W-1:0] count_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             load;
  logic             shift_en;

  // Seed the MISR on an accepted start; compact only valid words while compacting.
  always_comb begin
    load     = start && (state_q == StIdle || state_q == StDone);
    shift_en = (state_q == StCompact) && resp_valid;
  end

  misr_reg #(
    .WIDTH(WIDTH),
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift_en(shift_en),
    .din     (resp_in),
    .q       (signature)
  );

  // Run control FSM with pattern counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StCompact;
            count_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        StCompact: begin
          if (resp_valid) begin
            // Terminal count is checked first so the counter never wraps.
            if (count_q == LastCount) begin
              state_q <= StCompare;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        StCompare: begin
          pass_q  <= (signature == golden);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;

endmodule

// File: tb/tb_misr_signature_checker.sv
// Directed bench for misr_signature_checker with NUM_PATTERNS=2, SEED=0, POLY=0xB8.
module tb_misr_signature_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       resp_valid;
  logic [7:0] resp_in;
  logic [7:0] golden;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] signature;

  int total = 0;
  int bad   = 0;

  misr_signature_checker #(
    .WIDTH       (8),
    .POLY        (8'hB8),
    .SEED        (8'h00),
    .NUM_PATTERNS(2),
    .CNT_W       (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .resp_valid(resp_valid),
    .resp_in   (resp_in),
    .golden    (golden),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic b, input logic d, input logic p,
                              input logic [7:0] s);
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".pass"}, 32'(pass), 32'(p));
    check({tag, ".sig"}, 32'(signature), 32'(s));
  endtask

  initial begin
    int waited;
    rst = 1'b1; start = 1'b0; resp_valid = 1'b0; resp_in = 8'h00; golden = 8'h01;

    // Reset then idle
    step(); step();
    rst = 1'b0;
    check_status("reset", 1'b0, 1'b0, 1'b0, 8'h00);
    resp_valid = 1'b1; resp_in = 8'h5A;
    step();
    check_status("idle_valid_ignored", 1'b0, 1'b0, 1'b0, 8'h00);
    resp_valid = 1'b0;

    // Basic run: 0x80 then 0x00 gives 0x80 then 0x01
    start = 1'b1;
    step();
    start = 1'b0;
    check_status("basic_start", 1'b1, 1'b0, 1'b0, 8'h00);
    resp_valid = 1'b1; resp_in = 8'h80;
    step();
    check_status("basic_w0", 1'b1, 1'b0, 1'b0, 8'h80);
    resp_in = 8'h00;
    step();
    resp_valid = 1'b0;
    check_status("basic_compare", 1'b1, 1'b0, 1'b0, 8'h01);
    step();
    check_status("basic_done", 1'b0, 1'b1, 1'b1, 8'h01);

    // Valid words in DONE are ignored
    resp_valid = 1'b1; resp_in = 8'hFF;
    step();
    resp_valid = 1'b0;
    check_status("done_hold", 1'b0, 1'b1, 1'b1, 8'h01);

    // Restart from DONE clears status and reseeds
    start = 1'b1;
    step();
    start = 1'b0;
    check_status("restart", 1'b1, 1'b0, 1'b0, 8'h00);

    // Mismatch: 0x01, 0x02 gives 0x00, golden 0x01
    resp_valid = 1'b1; resp_in = 8'h01;
    step();
    check("mis_w0.sig", 32'(signature), 32'h01);
    resp_in = 8'h02;
    step();
    resp_valid = 1'b0;
    step();
    check_status("mis_done", 1'b0, 1'b1, 1'b0, 8'h00);

    // Gapped run with a start pulse ignored during COMPACT
    start = 1'b1;
    step();
    start = 1'b0;
    resp_valid = 1'b1; resp_in = 8'h80;
    step();
    resp_valid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      start = (g == 1);
      step();
      check_status($sformatf("gap%0d", g), 1'b1, 1'b0, 1'b0, 8'h80);
    end
    start = 1'b0;
    resp_valid = 1'b1; resp_in = 8'h00;
    step();
    resp_valid = 1'b0;
    step();
    check_status("gap_done", 1'b0, 1'b1, 1'b1, 8'h01);

    // Reset mid-run after one of two responses
    start = 1'b1;
    step();
    start = 1'b0;
    resp_valid = 1'b1; resp_in = 8'h80;
    step();
    resp_valid = 1'b0;
    check("mid_w0.sig", 32'(signature), 32'h80);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_status("mid_reset", 1'b0, 1'b0, 1'b0, 8'h00);

    // Fresh full run after reset, done awaited with a bounded wait
    start = 1'b1;
    step();
    start = 1'b0;
    resp_valid = 1'b1; resp_in = 8'h80;
    step();
    resp_in = 8'h00;
    step();
    resp_valid = 1'b0;
    waited = 0;
    while (done !== 1'b1 && waited < 10) begin
      step();
      waited++;
    end
    check("final_done_latency", 32'(waited), 32'd1);
    check_status("final_done", 1'b0, 1'b1, 1'b1, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
